ref_frame_store: RTL and testbench
==================================

# ref_frame_store

Streaming successor to the whole-frame reference buffer in the camera decoder loop-filter path. Accepts filtered pixels one per cycle in raster order, writes them into one of NUM_SLOTS frame slots in on-chip SRAM, and maintains an age-ordered reference list. The motion-compensation stage reads any reference pixel by (age index, x, y) with fixed latency. Slot allocation and eviction replace the old circular whole-array copy.

## Interface
- PIX_W, 8, pixel width in bits
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- NUM_SLOTS, 4, frame slots (≥2)
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- wr_start  in  1  pulse: begin a new frame
- wr_valid  in  1  pixel valid
- wr_ready  out  1  store can accept a pixel
- wr_data  in  PIX_W  pixel
- frame_done  out  1  pulse: frame committed
- rd_req  in  1  read request
- rd_ref  in  clog2(NUM_SLOTS)  age index, 0 = newest
- rd_x, rd_y  in  clog2(WIDTH), clog2(HEIGHT)  coordinates
- rd_valid  out  1  read data valid
- rd_data  out  PIX_W  pixel
- rd_err  out  1  with rd_valid: invalid ref or coordinate
- num_refs  out  clog2(NUM_SLOTS)+1  committed references
- ltr_mark  in  1  pulse: pin newest reference long-term (macro only)

## Operation
- FSM IDLE → WRITE on wr_start; WRITE → COMMIT after WIDTH*HEIGHT accepted pixels; COMMIT → IDLE after one cycle.
- wr_ready = 1 only in WRITE.
- Slot choice at wr_start: lowest-numbered free slot; if none, oldest non-pinned reference is evicted immediately (num_refs drops the same cycle).
- Write address = slot*WIDTH*HEIGHT + y*WIDTH + x; x wraps at WIDTH-1, incrementing y.
- COMMIT: slot inserted at age 0, others shift +1; frame_done pulses; num_refs +1.
- wr_start outside IDLE: ignored. wr_valid outside WRITE: ignored.
- Read: rd_ref ≥ num_refs, rd_x ≥ WIDTH or rd_y ≥ HEIGHT → rd_err=1, rd_data=0.
- Read resolves age index against the list as registered in the rd_req cycle; a commit in the same cycle does not affect it.
- Slot being written is never readable.
- Reset: FSM IDLE, list empty, num_refs=0; partial frame discarded; SRAM contents not cleared.

## Timing
- Reset values: wr_ready=0, frame_done=0, rd_valid=0, rd_data=0, rd_err=0, num_refs=0.
- Write throughput 1 pixel/cycle; frame_done asserts the cycle after the last pixel is accepted.
- Read latency 2 cycles (address register + SRAM), fully pipelined, one request per cycle.
- Reads and writes proceed concurrently on separate SRAM ports.

## Configuration
- FBM_LONG_TERM_REF_EN defined: ltr_mark pins the age-0 reference. A pinned slot is never evicted and stays in the age list. Only one slot may be pinned; a new mark moves the pin. With every slot pinned or writing, eviction takes the oldest unpinned reference.
- Undefined: ltr_mark ignored, pure oldest-first eviction.

## Structure
- Package fbm_pkg: FSM state enum, slot-index and address typedefs, FRAME_PIXELS constant.
- Sub-module fbm_sram: simple dual-port RAM, NUM_SLOTS*WIDTH*HEIGHT × PIX_W, 1-cycle registered read.

## Test plan
- Test geometry: WIDTH=4, HEIGHT=2, NUM_SLOTS=3.
- Reset, write frame of values 0..7 → frame_done after 8th pixel, num_refs=1; read (0,3,1) → rd_data=7 two cycles later.
- Four frames A,B,C,D → at D's wr_start num_refs drops 3→2 (A evicted); after commit, ref 0=D, ref 2=B.
- Read ref 2 with num_refs=1, and rd_x=4 → rd_err=1, rd_data=0.
- rd_req for ref 0 in the frame_done cycle → returns previous newest frame.
- Reset asserted mid-write at pixel 5 → num_refs=0, wr_ready=0; next frame writes normally.
- FBM_LONG_TERM_REF_EN: mark A, write B,C,D → B evicted, not A; A remains at age 2.

Source files
------------

// File: rtl/fbm_pkg.sv
// Shared types and default geometry for the reference frame store.
// The top module re-derives widths from its own parameters; these defaults describe the production geometry.
package fbm_pkg;

  localparam int DEF_WIDTH     = 640;
  localparam int DEF_HEIGHT    = 480;
  localparam int DEF_NUM_SLOTS = 4;
  localparam int FRAME_PIXELS  = DEF_WIDTH * DEF_HEIGHT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_COMMIT = 2'd2
  } fsm_state_t;

  typedef logic [$clog2(DEF_NUM_SLOTS)-1:0]                slot_idx_t;
  typedef logic [$clog2(DEF_NUM_SLOTS*FRAME_PIXELS)-1:0]   sram_addr_t;

endpackage

// File: rtl/fbm_sram.sv
// Simple dual-port frame SRAM: one write port, one read port with registered output.
// i_rclr forces the read register to zero so rejected reads return a clean pixel.
module fbm_sram #(
  parameter int DW    = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic          i_rclr,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Write port: array contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: one-cycle registered read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rclr ? '0 : r_mem[i_raddr];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ref_frame_store.sv
// Streaming reference frame store: raster writes into free/evicted slots, age-ordered reads.
// Build option FBM_LONG_TERM_REF_EN: ltr_mark pins the newest reference against eviction.
module ref_frame_store
  import fbm_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  // One spare coordinate code for power-of-two geometries keeps out-of-range reads expressible.
  parameter int XW        = $clog2(WIDTH + 1),
  parameter int YW        = $clog2(HEIGHT + 1),
  parameter int SW        = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_start,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [PIX_W-1:0] wr_data,
  output logic             frame_done,
  input  logic             rd_req,
  input  logic [SW-1:0]    rd_ref,
  input  logic [XW-1:0]    rd_x,
  input  logic [YW-1:0]    rd_y,
  output logic             rd_valid,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_err,
  output logic [SW:0]      num_refs,
  input  logic             ltr_mark
);

  localparam int            FP       = WIDTH * HEIGHT;
  localparam int            DEPTH    = NUM_SLOTS * FP;
  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(FP);
  localparam logic [AW-1:0] FP_A     = AW'(FP);
  localparam logic [AW-1:0] W_A      = AW'(WIDTH);
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [SW:0]   ONE_R    = (SW+1)'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FP - 1);
  localparam logic [XW-1:0] X_LIM    = XW'(WIDTH);
  localparam logic [YW-1:0] Y_LIM    = YW'(HEIGHT);

  fsm_state_t       r_state, w_state_nxt;
  logic [SW-1:0]    r_list [NUM_SLOTS];
  logic [SW:0]      r_num_refs;
  logic [SW-1:0]    r_slot;
  logic [AW-1:0]    r_wr_addr;
  logic [CW-1:0]    r_cnt;
  logic             r_wr_ready, r_frame_done;
  logic             r_rd_v1, r_rd_err1, r_rd_v2, r_rd_err2;
  logic [AW-1:0]    r_rd_addr;
  logic             w_accept, w_last, w_start;
  logic [NUM_SLOTS-1:0] w_in_use;
  logic             w_free_found;
  logic [SW-1:0]    w_free_slot, w_evict_age, w_new_slot, w_rd_slot;
  logic             w_rd_err;
  logic [AW-1:0]    w_rd_addr;
  logic [PIX_W-1:0] w_sram_q;

  assign w_accept = r_wr_ready & wr_valid;
  assign w_last   = w_accept & (r_cnt == CNT_LAST);
  assign w_start  = (r_state == ST_IDLE) & wr_start;

`ifdef FBM_LONG_TERM_REF_EN
  logic          r_pin_vld;
  logic [SW-1:0] r_pin_slot;

  // Long-term pin: a new mark simply moves the single pin to the current newest slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pin_vld  <= 1'b0;
      r_pin_slot <= '0;
    end else if (ltr_mark && (r_num_refs != '0)) begin
      r_pin_vld  <= 1'b1;
      r_pin_slot <= r_list[0];
    end else begin
      r_pin_vld  <= r_pin_vld;
      r_pin_slot <= r_pin_slot;
    end
  end
`else
  logic w_ltr_unused;
  assign w_ltr_unused = ltr_mark;
`endif

  // Next-state logic for the write FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   w_state_nxt = wr_start ? ST_WRITE : ST_IDLE;
      ST_WRITE:  w_state_nxt = w_last ? ST_COMMIT : ST_WRITE;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slot allocation: lowest free slot, else the oldest reference that is not pinned.
  always_comb begin
    w_in_use     = '0;
    w_free_found = 1'b0;
    w_free_slot  = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        w_in_use[s] = w_in_use[s] | (((SW+1)'(i) < r_num_refs) & (r_list[i] == SW'(s)));
      end
    end
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      w_free_slot  = w_in_use[s] ? w_free_slot : SW'(s);
      w_free_found = w_free_found | ~w_in_use[s];
    end
    w_evict_age = SW'(NUM_SLOTS - 1);
`ifdef FBM_LONG_TERM_REF_EN
    if (r_pin_vld && (r_list[NUM_SLOTS-1] == r_pin_slot)) begin
      w_evict_age = SW'(NUM_SLOTS - 2);
    end else begin
      w_evict_age = SW'(NUM_SLOTS - 1);
    end
`endif
    w_new_slot = w_free_found ? w_free_slot : r_list[w_evict_age];
  end

  // Write pointer, age list and reference count; the list only changes at allocation and commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_list[i] <= '0;
      end
      r_num_refs   <= '0;
      r_slot       <= '0;
      r_wr_addr    <= '0;
      r_cnt        <= '0;
      r_wr_ready   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_ready   <= (w_state_nxt == ST_WRITE);
      r_frame_done <= w_last;
      if (w_start) begin
        r_slot    <= w_new_slot;
        r_wr_addr <= AW'(w_new_slot) * FP_A;
        r_cnt     <= '0;
        if (!w_free_found) begin
          for (int i = 0; i < NUM_SLOTS - 1; i++) begin
            if (i >= int'(w_evict_age)) begin
              r_list[i] <= r_list[i+1];
            end
          end
          r_num_refs <= r_num_refs - ONE_R;
        end
      end else if (w_accept) begin
        r_wr_addr <= r_wr_addr + ONE_A;
        r_cnt     <= r_cnt + ONE_C;
      end
      if (r_state == ST_COMMIT) begin
        r_list[0] <= r_slot;
        for (int i = 1; i < NUM_SLOTS; i++) begin
          r_list[i] <= r_list[i-1];
        end
        r_num_refs <= r_num_refs + ONE_R;
      end
    end
  end

  // Read request decode against the list as registered this cycle.
  always_comb begin
    w_rd_slot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_rd_slot = (rd_ref == SW'(i)) ? r_list[i] : w_rd_slot;
    end
    w_rd_err  = ({1'b0, rd_ref} >= r_num_refs) | (rd_x >= X_LIM) | (rd_y >= Y_LIM);
    w_rd_addr = AW'(w_rd_slot) * FP_A + AW'(rd_y) * W_A + AW'(rd_x);
  end

  // Read pipeline: address register, then SRAM register with valid/error alongside.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_v1   <= 1'b0;
      r_rd_err1 <= 1'b0;
      r_rd_addr <= '0;
      r_rd_v2   <= 1'b0;
      r_rd_err2 <= 1'b0;
    end else begin
      r_rd_v1   <= rd_req;
      r_rd_err1 <= rd_req & w_rd_err;
      r_rd_addr <= w_rd_addr;
      r_rd_v2   <= r_rd_v1;
      r_rd_err2 <= r_rd_err1;
    end
  end

  fbm_sram #(
    .DW    (PIX_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_accept),
    .i_waddr (r_wr_addr),
    .i_wdata (wr_data),
    .i_re    (r_rd_v1),
    .i_rclr  (r_rd_err1),
    .i_raddr (r_rd_addr),
    .o_rdata (w_sram_q)
  );

  assign wr_ready   = r_wr_ready;
  assign frame_done = r_frame_done;
  assign rd_valid   = r_rd_v2;
  assign rd_err     = r_rd_err2;
  assign rd_data    = w_sram_q;
  assign num_refs   = r_num_refs;

endmodule

// File: tb/tb_ref_frame_store.sv
// Directed bench for ref_frame_store at 4x2 pixels, 3 slots; read checks driven from a vector table.
module tb_ref_frame_store;

  typedef struct {
    logic [1:0] ref_i;
    logic [2:0] x;
    logic [1:0] y;
    logic       err;
    logic [7:0] data;
  } rd_vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_start, wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       frame_done;
  logic       rd_req;
  logic [1:0] rd_ref;
  logic [2:0] rd_x;
  logic [1:0] rd_y;
  logic       rd_valid, rd_err;
  logic [7:0] rd_data;
  logic [2:0] num_refs;
  logic       ltr_mark;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] refs_at_start;
  rd_vec_t    vecs[21];

  always #5 clk = ~clk;

  ref_frame_store #(
    .PIX_W(8), .WIDTH(4), .HEIGHT(2), .NUM_SLOTS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_start(wr_start), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .frame_done(frame_done),
    .rd_req(rd_req), .rd_ref(rd_ref), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .num_refs(num_refs), .ltr_mark(ltr_mark)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts a frame and feeds npix pixels base+i; leaves the bench just after the last accepting edge.
  task automatic write_frame(input logic [7:0] base, input int npix);
    wr_start = 1'b1;
    tick;
    wr_start = 1'b0;
    refs_at_start = num_refs;
    check("wr_ready_in_write", wr_ready, 32'd1);
    for (int i = 0; i < npix; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 8'(i);
      tick;
      if (i == 7) check("frame_done_after_last", frame_done, 32'd1);
      else        check("frame_done_early", frame_done, 32'd0);
    end
    wr_valid = 1'b0;
  endtask

  // Issues vecs[lo..hi] back-to-back and checks each result two cycles after its request.
  task automatic run_reads(input int lo, input int hi);
    for (int i = lo; i <= hi + 1; i++) begin
      if (i <= hi) begin
        rd_req = 1'b1;
        rd_ref = vecs[i].ref_i;
        rd_x   = vecs[i].x;
        rd_y   = vecs[i].y;
      end else begin
        rd_req = 1'b0;
      end
      tick;
      if (i > lo) begin
        check($sformatf("rd%0d_valid", i-1), rd_valid, 32'd1);
        check($sformatf("rd%0d_err", i-1), rd_err, 32'(vecs[i-1].err));
        check($sformatf("rd%0d_data", i-1), rd_data, 32'(vecs[i-1].data));
      end
    end
    tick;
    check("rd_idle_valid", rd_valid, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ref, x, y, err, data
    vecs[0]  = '{2'd0, 3'd3, 2'd1, 1'b0, 8'h07};
    vecs[1]  = '{2'd0, 3'd0, 2'd0, 1'b0, 8'h00};
    vecs[2]  = '{2'd0, 3'd2, 2'd1, 1'b0, 8'h06};
    vecs[3]  = '{2'd2, 3'd0, 2'd0, 1'b1, 8'h00};
    vecs[4]  = '{2'd0, 3'd4, 2'd0, 1'b1, 8'h00};
    vecs[5]  = '{2'd0, 3'd0, 2'd2, 1'b1, 8'h00};
    vecs[6]  = '{2'd1, 3'd0, 2'd0, 1'b1, 8'h00};
    vecs[7]  = '{2'd0, 3'd0, 2'd0, 1'b0, 8'h30};
    vecs[8]  = '{2'd1, 3'd1, 2'd0, 1'b0, 8'h21};
    vecs[9]  = '{2'd2, 3'd3, 2'd1, 1'b0, 8'h17};
    vecs[10] = '{2'd3, 3'd0, 2'd0, 1'b1, 8'h00};
    vecs[11] = '{2'd2, 3'd0, 2'd3, 1'b1, 8'h00};
    vecs[12] = '{2'd0, 3'd1, 2'd1, 1'b0, 8'h45};
    vecs[13] = '{2'd1, 3'd0, 2'd0, 1'b0, 8'h30};
    vecs[14] = '{2'd2, 3'd0, 2'd1, 1'b0, 8'h24};
    vecs[15] = '{2'd0, 3'd3, 2'd1, 1'b0, 8'h67};
    vecs[16] = '{2'd0, 3'd1, 2'd0, 1'b0, 8'h61};
    vecs[17] = '{2'd1, 3'd0, 2'd0, 1'b1, 8'h00};
    vecs[18] = '{2'd2, 3'd2, 2'd0, 1'b0, 8'h72};
    vecs[19] = '{2'd1, 3'd0, 2'd0, 1'b0, 8'h90};
    vecs[20] = '{2'd0, 3'd0, 2'd0, 1'b0, 8'hA0};

    reset_n  = 1'b0;
    wr_start = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rd_req   = 1'b0;
    rd_ref   = 2'd0;
    rd_x     = 3'd0;
    rd_y     = 2'd0;
    ltr_mark = 1'b0;
    tick;
    tick;
    check("rst_wr_ready", wr_ready, 32'd0);
    check("rst_frame_done", frame_done, 32'd0);
    check("rst_rd_valid", rd_valid, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_rd_err", rd_err, 32'd0);
    check("rst_num_refs", num_refs, 32'd0);
    reset_n = 1'b1;
    tick;

    // Frame A = 0..7, then reads including out-of-range ref/coordinates.
    write_frame(8'h00, 8);
    tick;
    check("a_num_refs", num_refs, 32'd1);
    check("a_frame_done_pulse", frame_done, 32'd0);
    check("a_wr_ready_idle", wr_ready, 32'd0);
    run_reads(0, 6);

    // Frames B, C fill the store; D evicts A at its start.
    write_frame(8'h10, 8);
    tick;
    write_frame(8'h20, 8);
    tick;
    check("c_num_refs_full", num_refs, 32'd3);
    write_frame(8'h30, 8);
    check("d_evict_drop", refs_at_start, 32'd2);
    tick;
    check("d_num_refs", num_refs, 32'd3);
    run_reads(7, 11);

    // Frame E: a read of ref 0 in the frame_done cycle still sees D.
    write_frame(8'h40, 8);
    check("e_evict_drop", refs_at_start, 32'd2);
    rd_req = 1'b1;
    rd_ref = 2'd0;
    rd_x   = 3'd1;
    rd_y   = 2'd0;
    tick;
    rd_req = 1'b0;
    check("e_num_refs", num_refs, 32'd3);
    tick;
    check("done_rd_valid", rd_valid, 32'd1);
    check("done_rd_err", rd_err, 32'd0);
    check("done_rd_data", rd_data, 32'h31);
    run_reads(12, 14);

    // Reset in the middle of a frame discards it and empties the list.
    write_frame(8'h50, 5);
    reset_n = 1'b0;
    #2;
    check("midrst_num_refs", num_refs, 32'd0);
    check("midrst_wr_ready", wr_ready, 32'd0);
    check("midrst_frame_done", frame_done, 32'd0);
    reset_n = 1'b1;
    tick;
    write_frame(8'h60, 8);
    tick;
    check("g_num_refs", num_refs, 32'd1);
    run_reads(15, 17);

`ifdef FBM_LONG_TERM_REF_EN
    // Pinned A survives the eviction that D triggers; B goes instead.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick;
    write_frame(8'h70, 8);
    tick;
    ltr_mark = 1'b1;
    tick;
    ltr_mark = 1'b0;
    write_frame(8'h80, 8);
    tick;
    write_frame(8'h90, 8);
    tick;
    write_frame(8'hA0, 8);
    check("ltr_evict_drop", refs_at_start, 32'd2);
    tick;
    check("ltr_num_refs", num_refs, 32'd3);
    run_reads(18, 20);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
